// File: rtl/memctrl.sv
// memctrl: serves the D-cache request port and I-cache fetch port over a byte-wide RAM/IO bus,
// one byte per cycle. Define IO_BUFFER_STALL_EN to stall writes to 0x30000-0x3FFFF while io_buffer_full is high.
module memctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iDC_en,
    input  logic        iDC_ls,
    input  logic [31:0] iDC_pc,
    input  logic [31:0] iDC_dt,
    input  logic [2:0]  iDC_len,
    output logic        oDC_done,
    output logic [31:0] oDC_dt,
    input  logic        iIC_en,
    input  logic [31:0] iIC_pc,
    output logic        oIC_done,
    output logic [31:0] oIC_dt,
    output logic [1:0]  oWait,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DREAD  = 3'd1;
    localparam logic [2:0] S_DWRITE = 3'd2;
    localparam logic [2:0] S_IREAD  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] dt;
    logic [31:0] rbuf;
    logic [2:0]  len;
    logic [2:0]  iss;
    logic [2:0]  rcv;
    logic        dc_own;

    logic        read_st;
    logic        issue_ok;
    logic        capture;
    logic        read_fin;
    logic        wr_go;
    logic        write_fin;
    logic        io_stall;
    logic [2:0]  rcv_next;
    logic [31:0] cap_buf;
    logic [31:0] bus_addr;

    function automatic logic [2:0] clamp_len(input logic [2:0] l);
        return (l > 3'd4) ? 3'd4 : l;
    endfunction

    assign read_st  = (state == S_DREAD) || (state == S_IREAD);
    assign issue_ok = iss < len;
    assign bus_addr = pc + {29'd0, iss};

    // A byte is captured on every edge where an earlier issue is still outstanding.
    assign capture  = read_st && rdy && (rcv < iss);
    assign rcv_next = rcv + {2'd0, capture};
    assign cap_buf  = capture ? (rbuf | ({24'd0, mem_din} << {rcv[1:0], 3'b000})) : rbuf;
    assign read_fin = read_st && rdy && (rcv_next == len);

`ifdef IO_BUFFER_STALL_EN
    assign io_stall = (state == S_DWRITE) && io_buffer_full && (bus_addr[31:16] == 16'h0003);
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign io_stall  = 1'b0;
`endif

    assign wr_go     = (state == S_DWRITE) && rdy && issue_ok && !io_stall;
    assign write_fin = (state == S_DWRITE) && rdy &&
                       ((wr_go && (({1'b0, iss} + 4'd1) == {1'b0, len})) || (len == 3'd0));

    assign oWait[0] = (state != S_IDLE);
    assign oWait[1] = read_st || (state == S_DWRITE) || ((state == S_DONE) && dc_own);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        if (read_st) begin
            // While paused, keep the oldest outstanding address on the bus so the resume capture is right.
            mem_a = (rdy && issue_ok) ? bus_addr : pc + {29'd0, rcv};
        end else if ((state == S_DWRITE) && issue_ok) begin
            mem_a    = bus_addr;
            mem_dout = dt[{iss[1:0], 3'b000} +: 8];
            mem_wr   = rdy && !io_stall;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= 32'd0;
            dt       <= 32'd0;
            rbuf     <= 32'd0;
            len      <= 3'd0;
            iss      <= 3'd0;
            rcv      <= 3'd0;
            dc_own   <= 1'b0;
            oDC_done <= 1'b0;
            oDC_dt   <= 32'd0;
            oIC_done <= 1'b0;
            oIC_dt   <= 32'd0;
        end else begin
            oDC_done <= 1'b0;
            oIC_done <= 1'b0;
            if (rdy) begin
                case (state)
                    S_IDLE: begin
                        iss  <= 3'd0;
                        rcv  <= 3'd0;
                        rbuf <= 32'd0;
                        if (iDC_en) begin
                            state  <= iDC_ls ? S_DWRITE : S_DREAD;
                            pc     <= iDC_pc;
                            dt     <= iDC_dt;
                            len    <= clamp_len(iDC_len);
                            dc_own <= 1'b1;
                        end else if (iIC_en) begin
                            state  <= S_IREAD;
                            pc     <= iIC_pc;
                            dt     <= 32'd0;
                            len    <= 3'd4;
                            dc_own <= 1'b0;
                        end
                    end
                    S_DREAD, S_IREAD: begin
                        if (issue_ok) iss <= iss + 3'd1;
                        rcv  <= rcv_next;
                        rbuf <= cap_buf;
                        if (read_fin) begin
                            state <= S_DONE;
                            if (dc_own) begin
                                oDC_done <= 1'b1;
                                oDC_dt   <= cap_buf;
                            end else begin
                                oIC_done <= 1'b1;
                                oIC_dt   <= cap_buf;
                            end
                        end
                    end
                    S_DWRITE: begin
                        if (wr_go) iss <= iss + 3'd1;
                        if (write_fin) begin
                            state    <= S_DONE;
                            oDC_done <= 1'b1;
                            oDC_dt   <= 32'd0;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memctrl.sv
// Self-checking bench for memctrl: byte RAM on the bus, transaction-level memory model,
// directed cases plus randomized loads/stores/fetches with random pauses.
module tb_memctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iDC_en, iDC_ls;
    logic [31:0] iDC_pc, iDC_dt;
    logic [2:0]  iDC_len;
    logic        oDC_done;
    logic [31:0] oDC_dt;
    logic        iIC_en;
    logic [31:0] iIC_pc;
    logic        oIC_done;
    logic [31:0] oIC_dt;
    logic [1:0]  oWait;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    memctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iDC_en(iDC_en), .iDC_ls(iDC_ls), .iDC_pc(iDC_pc), .iDC_dt(iDC_dt), .iDC_len(iDC_len),
        .oDC_done(oDC_done), .oDC_dt(oDC_dt),
        .iIC_en(iIC_en), .iIC_pc(iIC_pc), .oIC_done(oIC_done), .oIC_dt(oIC_dt),
        .oWait(oWait),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Power-on RAM contents: 11,22,33,44 at 0x1000..0x1003, a hash elsewhere.
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        if (a >= 16'h1000 && a <= 16'h1003) return 8'h11 * 8'(a - 16'h0fff);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    // Bus-side RAM (written only by the DUT) and the bench's own expected memory.
    logic [7:0] ram [0:65535];
    logic [7:0] model_mem [0:65535];
    bit ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
        end
        mem_din <= ram_ready ? ram[mem_a[15:0]] : init_byte(mem_a[15:0]);
    end

    int wr_total  = 0;
    int both_done = 0;
    int bad_wr    = 0;
    always @(negedge clk) begin
        if (mem_wr) wr_total++;
        if (oDC_done && oIC_done) both_done++;
        if (!rdy && mem_wr) bad_wr++;
    end

    // One request from the idle controller; the bench computes data, latency and RAM effects itself.
    task automatic xfer(input string name, input bit ic, input bit ls, input logic [31:0] pc,
                        input logic [31:0] dt, input logic [2:0] len,
                        input int rdy_k, input int rdy_n, input int io_n, output logic [31:0] got);
        int n, base, exp_lat, io_extra, k, wr_base;
        logic [31:0] exp;
        logic [31:0] a;
        logic [1:0]  wt0, wtd;
        bit seen;
        n   = ic ? 4 : ((len > 3'd4) ? 4 : int'(len));
        exp = 32'd0;
        if (ls && !ic) begin
            for (int i = 0; i < n; i++) begin
                a = pc + 32'(i);
                model_mem[a[15:0]] = dt[8*i +: 8];
            end
            base = (n == 0) ? 1 : n;
        end else begin
            for (int i = 0; i < n; i++) begin
                a = pc + 32'(i);
                exp = exp | (32'(model_mem[a[15:0]]) << (8 * i));
            end
            base = n + 1;
        end
`ifdef IO_BUFFER_STALL_EN
        io_extra = (ls && !ic && pc[31:16] == 16'h0003) ? io_n : 0;
`else
        io_extra = 0;
`endif
        if (rdy_n > 0 && rdy_k >= base) rdy_k = base - 1;
        exp_lat = base + rdy_n + io_extra;
        wr_base = wr_total;
        if (ic) begin
            iIC_en = 1'b1; iIC_pc = pc;
        end else begin
            iDC_en = 1'b1; iDC_ls = ls; iDC_pc = pc; iDC_dt = dt; iDC_len = len;
        end
        io_buffer_full = (io_n > 0);
        k = -1; seen = 1'b0; got = 32'd0; wt0 = 2'b00; wtd = 2'b00;
        while (!seen && k < 60) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 0) wt0 = oWait;
            if (rdy_n > 0 && k == rdy_k) rdy = 1'b0;
            if (rdy_n > 0 && k == rdy_k + rdy_n) rdy = 1'b1;
            if (io_n > 0 && k == io_n) io_buffer_full = 1'b0;
            if (ic ? oIC_done : oDC_done) begin
                seen = 1'b1;
                got  = ic ? oIC_dt : oDC_dt;
                wtd  = oWait;
            end
        end
        iDC_en = 1'b0; iIC_en = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        check({name, ".done"}, 64'(seen), 64'd1);
        check({name, ".data"}, 64'(got), 64'(exp));
        check({name, ".lat"}, 64'(k), 64'(exp_lat));
        check({name, ".wait0"}, 64'(wt0), 64'd3);
        check({name, ".waitd"}, 64'(wtd), ic ? 64'd1 : 64'd3);
        check({name, ".nwr"}, 64'(wr_total - wr_base), (ls && !ic) ? 64'(n) : 64'd0);
        if (ls && !ic) begin
            for (int i = 0; i <= n; i++) begin
                a = pc + 32'(i);
                check($sformatf("%s.ram%0d", name, i), 64'(ram[a[15:0]]), 64'(model_mem[a[15:0]]));
            end
        end
        @(negedge clk);
        check({name, ".idle"}, 64'(oWait), 64'd0);
    endtask

    initial begin
        logic [31:0] got, word0, sdt;
        int k, k_dc, kind;
        int lens [8] = '{0, 1, 2, 3, 4, 5, 7, 4};
        logic [31:0] rpc;

        for (int i = 0; i < 65536; i++) model_mem[i] = init_byte(16'(i));
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        iDC_en = 1'b0; iDC_ls = 1'b0; iDC_pc = '0; iDC_dt = '0; iDC_len = '0;
        iIC_en = 1'b0; iIC_pc = '0;
        @(posedge clk); @(negedge clk);
        check("rst.dt", {oDC_dt, oIC_dt}, 64'd0);
        check("rst.ctl", {19'd0, oDC_done, oIC_done, oWait, mem_wr, mem_dout, mem_a}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        xfer("load4", 0, 0, 32'h1000, 32'h0, 3'd4, -10, 0, 0, got);
        check("load4.spec", 64'(got), 64'h4433_2211);
        xfer("store2", 0, 1, 32'h2000, 32'hABCD_1234, 3'd2, -10, 0, 0, got);
        check("store2.b0", 64'(ram[16'h2000]), 64'h34);
        check("store2.b1", 64'(ram[16'h2001]), 64'h12);

        // Data and fetch requests raised together: data first, then the fetch.
        word0 = {model_mem[3], model_mem[2], model_mem[1], model_mem[0]};
        iDC_en = 1'b1; iDC_ls = 1'b0; iDC_pc = 32'h1000; iDC_len = 3'd4;
        iIC_en = 1'b1; iIC_pc = 32'h0;
        k = -1; k_dc = -1;
        while (k_dc < 0 && k < 40) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 0) check("arb.wait", 64'(oWait), 64'd3);
            if (oDC_done) begin
                k_dc = k;
                check("arb.dc_data", 64'(oDC_dt), 64'h4433_2211);
                check("arb.ic_not_yet", 64'(oIC_done), 64'd0);
            end
        end
        check("arb.dc_lat", 64'(k_dc), 64'd5);
        iDC_en = 1'b0;
        while (!oIC_done && k < 80) begin
            @(posedge clk); k++;
            @(negedge clk);
        end
        check("arb.ic_done", 64'(oIC_done), 64'd1);
        check("arb.ic_data", 64'(oIC_dt), 64'(word0));
        iIC_en = 1'b0;
        @(negedge clk); @(negedge clk);

        xfer("pause", 0, 0, 32'h1000, 32'h0, 3'd4, 2, 3, 0, got);
        check("pause.spec", 64'(got), 64'h4433_2211);

        // Reset in the middle of a 4-byte store, while byte 1 is on the bus.
        sdt = $urandom;
        iDC_en = 1'b1; iDC_ls = 1'b1; iDC_pc = 32'h4000; iDC_dt = sdt; iDC_len = 3'd4;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.dt", {oDC_dt, oIC_dt}, 64'd0);
        check("midrst.ctl", {19'd0, oDC_done, oIC_done, oWait, mem_wr, mem_dout, mem_a}, 64'd0);
        model_mem[16'h4000] = sdt[7:0];
        @(negedge clk); iDC_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("midrst.b0", 64'(ram[16'h4000]), 64'(sdt[7:0]));
        check("midrst.b1", 64'(ram[16'h4001]), 64'(model_mem[16'h4001]));
        xfer("after_rst", 0, 0, 32'h4000, 32'h0, 3'd2, -10, 0, 0, got);

        xfer("load0", 0, 0, 32'h1000, 32'h0, 3'd0, -10, 0, 0, got);
        xfer("store0", 0, 1, 32'h2100, 32'hFFFF_FFFF, 3'd0, -10, 0, 0, got);
        xfer("load3", 0, 0, 32'h1001, 32'h0, 3'd3, -10, 0, 0, got);
        xfer("load7", 0, 0, 32'h1000, 32'h0, 3'd7, -10, 0, 0, got);
        xfer("store5", 0, 1, 32'h2200, 32'h8765_4321, 3'd5, -10, 0, 0, got);
        xfer("wrap", 0, 0, 32'hFFFF_FFFE, 32'h0, 3'd4, -10, 0, 0, got);
        xfer("fetch", 1, 0, 32'h1000, 32'h0, 3'd0, -10, 0, 0, got);
        xfer("iofull", 0, 1, 32'h0003_0010, 32'h0000_00A5, 3'd1, -10, 0, 2, got);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            rpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'h1000 + 32'($urandom_range(0, 12'hff0));
            xfer($sformatf("rnd%0d", t), kind == 2, kind == 1, rpc, $urandom,
                 3'(lens[$urandom_range(0, 7)]),
                 $urandom_range(0, 4), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0, 0, got);
        end

        check("no_dual_done", 64'(both_done), 64'd0);
        check("no_wr_paused", 64'(bad_wr), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
